// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for an RV64 subset datapath (ld, sd, R-type, beq).
// Steps FETCH/DECODE/EXEC/MEM/WB with a variable-latency memory handshake and a sticky trap.
module multicycle_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             regWrite,
  output logic             ALU_Src,
  output logic [1:0]       ALU_Op,
  output logic             Mem_Read,
  output logic             Mem_Write,
  output logic             Mem_to_Reg,
  output logic             Branch,
  output logic             busy,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    C_LD  = 2'd0,
    C_SD  = 2'd1,
    C_R   = 2'd2,
    C_BEQ = 2'd3
  } cls_t;

  state_t          state_q;
  state_t          state_d;
  cls_t            cls_q;
  cls_t            cls_d;
  logic [TO_W-1:0] wait_q;
  logic            retire;
  logic            timeout;
  logic            waiting;

  logic            pc_src_d;
  logic            reg_write_d;
  logic            alu_src_d;
  logic [1:0]      alu_op_d;
  logic            mem_read_d;
  logic            mem_write_d;
  logic            mem_to_reg_d;
  logic            branch_d;
  logic            busy_d;
  logic            illegal_d;

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timeout = waiting && !mem_ready && (wait_q == TO_W'(MEM_TIMEOUT));

  // Next-state, class latch and retire decision
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          OP_LD:   begin cls_d = C_LD;  state_d = S_EXEC; end
          OP_SD:   begin cls_d = C_SD;  state_d = S_EXEC; end
          OP_R:    begin cls_d = C_R;   state_d = S_EXEC; end
          OP_BEQ:  begin cls_d = C_BEQ; state_d = S_EXEC; end
          default: state_d = S_TRAP;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_BEQ: begin
            retire  = 1'b1;
            state_d = halt ? S_IDLE : S_FETCH;
          end
          C_R:     state_d = S_WB;
          default: state_d = S_MEM;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (cls_q == C_LD) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = halt ? S_IDLE : S_FETCH;
          end
        end else if (timeout) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = halt ? S_IDLE : S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore controls decoded from the upcoming state so they land registered with it
  always_comb begin
    pc_src_d     = 1'b0;
    reg_write_d  = 1'b0;
    alu_src_d    = 1'b0;
    alu_op_d     = ALU_ADD;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    branch_d     = 1'b0;
    case (state_d)
      S_FETCH: mem_read_d = 1'b1;
      S_EXEC: begin
        case (cls_d)
          C_BEQ: begin
            alu_op_d = ALU_SUB;
            branch_d = 1'b1;
            pc_src_d = 1'b1;
          end
          C_R:     alu_op_d  = ALU_FUNCT;
          default: alu_src_d = 1'b1;
        endcase
      end
      S_MEM: begin
        alu_src_d   = 1'b1;
        mem_read_d  = (cls_d == C_LD);
        mem_write_d = (cls_d == C_SD);
      end
      S_WB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = (cls_d == C_LD);
      end
      default: ;
    endcase
    busy_d    = (state_d != S_IDLE) && (state_d != S_TRAP);
    illegal_d = (state_d == S_TRAP);
  end

  // State, class, wait counter, retire counter and registered controls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cls_q         <= C_LD;
      wait_q        <= '0;
      retired_count <= '0;
      pc_src        <= 1'b0;
      regWrite      <= 1'b0;
      ALU_Src       <= 1'b0;
      ALU_Op        <= ALU_ADD;
      Mem_Read      <= 1'b0;
      Mem_Write     <= 1'b0;
      Mem_to_Reg    <= 1'b0;
      Branch        <= 1'b0;
      busy          <= 1'b0;
      illegal       <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      if (((state_d == S_FETCH) || (state_d == S_MEM)) && (state_d != state_q)) begin
        wait_q <= '0;
      end else if (waiting && !mem_ready) begin
        wait_q <= wait_q + TO_W'(1);
      end
      if (retire) retired_count <= retired_count + CNT_W'(1);
      pc_src     <= pc_src_d;
      regWrite   <= reg_write_d;
      ALU_Src    <= alu_src_d;
      ALU_Op     <= alu_op_d;
      Mem_Read   <= mem_read_d;
      Mem_Write  <= mem_write_d;
      Mem_to_Reg <= mem_to_reg_d;
      Branch     <= branch_d;
      busy       <= busy_d;
      illegal    <= illegal_d;
    end
  end

  // IR load and PC update pulses follow the live handshake and zero flag
  assign ir_write = (state_q == S_FETCH) && mem_ready;
  assign pc_write = ir_write || ((state_q == S_EXEC) && (cls_q == C_BEQ) && zero);
  assign state    = state_q;

endmodule
